song_reader: RTL and testbench
==============================

// Module: song_reader
// PURPOSE
//  Sequences the notes of the currently selected song for the note player.
//  Walks a synchronous song ROM. Presents each note/duration pair with a
//  one-cycle new_note pulse. Waits for note_done from the note player.
//  Pulses song_done at end of song so the MCU advances to the next song.
//  Sits between the MCU (play, song, song_done) and the note player.
// PARAMETERS
//  IDX_W   5  note-index width; NOTES_PER_SONG = 2**IDX_W = 32
//  NOTE_W  6  note code width (0 = rest)
//  DUR_W   6  duration width (0 = end-of-song marker)
// PORTS
//  clk        in   1                clock
//  reset      in   1                synchronous, active-high; MCU reset_player is ORed in
//  play       in   1                MCU play/pause level
//  song       in   2                selected song
//  note_done  in   1                note player: current note finished (1-cycle pulse)
//  rom_addr   out  2+IDX_W          {song_q, index} to song ROM
//  rom_data   in   NOTE_W+DUR_W     {note, duration}; valid 1 cycle after rom_addr
//  new_note   out  1                1-cycle pulse: note/duration valid, start playing
//  note       out  NOTE_W           registered note code
//  duration   out  DUR_W            registered duration
//  song_done  out  1                1-cycle pulse: song finished
// BEHAVIOUR
//  Reset (sync, overrides everything):
//   - state=IDLE, index=0, song_q=0, note=0, duration=0, new_note=0, song_done=0
//  States:
//   - IDLE: if play=1, song_q<=song -> FETCH; else stay. index held at 0.
//   - FETCH: rom_addr={song_q,index} is stable; always -> WAIT.
//   - WAIT: rom_data valid this cycle.
//       duration field==0 -> DONE. Note and duration are not updated.
//       else latch note/duration -> EMIT.
//   - EMIT: new_note=1 for exactly this cycle -> PLAYING.
//   - PLAYING: on note_done:
//       index==2**IDX_W-1 -> DONE
//       else index<=index+1 -> FETCH
//     Without note_done, stay; pause is handled by the note player.
//   - DONE: song_done=1 for exactly this cycle; index<=0 -> IDLE.
//  Timing:
//   - play seen high in IDLE at cycle t -> new_note high at t+3.
//   - note_done at cycle t (PLAYING, not last) -> next new_note at t+3.
//  Signal rules:
//   - rom_addr is driven combinationally from song_q and index in all states.
//   - song is sampled only on the IDLE->FETCH transition. A song change
//     mid-song takes effect only after reset or DONE.
//   - note and duration hold their last latched values until the next WAIT
//     with a nonzero duration.
//   - note==0 (rest) is emitted like any other note.
//   - note_done outside PLAYING is ignored, including in EMIT on the same
//     cycle as new_note.
//   - play low does not stall FETCH/WAIT/EMIT/PLAYING. It only gates
//     IDLE->FETCH.
//   - index never wraps. The last slot ends the song via DONE.
//   - new_note and song_done are never high in the same cycle.
// TESTING
//  1. Reset, play=1, song=2, ROM[{2,0}]={note 5, dur 10}
//     -> rom_addr=0x40 at t+1; new_note at t+3 with note=5, dur=10.
//  2. Song with 3 notes then dur=0 at index 3; pulse note_done after each new_note
//     -> exactly 3 new_note pulses; song_done 3 cycles after the 3rd note_done; back in IDLE.
//  3. Full 32-note song, no zero durations
//     -> 32 new_note pulses; song_done 1 cycle after the 32nd note_done; index returns to 0.
//  4. Assert reset while PLAYING at index 7
//     -> next cycle all outputs 0, state IDLE; replay starts from index 0.
//  5. note_done pulsed in IDLE, FETCH and EMIT
//     -> ignored; index unchanged; no extra new_note.
//  6. Change song from 1 to 3 during PLAYING
//     -> rom_addr keeps song 1 until song_done; the next play starts at {3,0}.

Source files
------------

// File: rtl/song_reader.sv
// rtl/song_reader.sv - walks the selected song in ROM and hands notes to the note player
module song_reader #(
    parameter int IDX_W  = 5,
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic [1:0]              song,
    input  logic                    note_done,
    output logic [IDX_W+1:0]        rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic                    new_note,
    output logic [NOTE_W-1:0]       note,
    output logic [DUR_W-1:0]        duration,
    output logic                    song_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_PLAYING,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [1:0]         song_q, song_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic [DUR_W-1:0]   duration_q, duration_d;

    logic [NOTE_W-1:0]  rom_note;
    logic [DUR_W-1:0]   rom_dur;
    logic               last_slot;

    assign rom_note  = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur   = rom_data[DUR_W-1:0];
    assign last_slot = (index_q == {IDX_W{1'b1}});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            song_q     <= '0;
            note_q     <= '0;
            duration_q <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            song_q     <= song_d;
            note_q     <= note_d;
            duration_q <= duration_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        song_d     = song_q;
        note_d     = note_q;
        duration_d = duration_q;
        new_note   = 1'b0;
        song_done  = 1'b0;

        case (state_q)
            S_IDLE: begin
                index_d = '0;
                if (play) begin
                    song_d  = song;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                // A zero duration marks the end of the song; keep the last note visible.
                if (rom_dur == '0) begin
                    state_d = S_DONE;
                end else begin
                    note_d     = rom_note;
                    duration_d = rom_dur;
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                new_note = 1'b1;
                state_d  = S_PLAYING;
            end
            S_PLAYING: begin
                if (note_done) begin
                    if (last_slot) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                song_done = 1'b1;
                index_d   = '0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rom_addr = {song_q, index_q};
    assign note     = note_q;
    assign duration = duration_q;

endmodule

// File: tb/tb_song_reader.sv
// tb/tb_song_reader.sv - randomized song ROM checked against a per-song note-list model
module tb_song_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic [1:0]  song;
    logic        note_done;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data = '0;
    logic        new_note;
    logic [5:0]  note;
    logic [5:0]  duration;
    logic        song_done;

    logic [11:0] rom [0:127];

    int total = 0;
    int bad   = 0;
    int last_song = 0;
    int last_note = 0;
    int last_dur  = 0;

    song_reader dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .new_note  (new_note),
        .note      (note),
        .duration  (duration),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            total++;
            assert (!(new_note === 1'b1 && song_done === 1'b1)) else begin
                bad++;
                $error("FAIL excl observed new_note=%0b song_done=%0b expected not both", new_note, song_done);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int song_len(input int s);
        for (int i = 0; i < 32; i++)
            if (rom[s * 32 + i][5:0] == 6'd0) return i;
        return 32;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_song(input int sng, input int new_sng, input bit stray, input int abort_at);
        int n;
        int nw;
        n = song_len(sng);
        if (stray) begin
            note_done = 1'b1;
            step();
            note_done = 1'b0;
            chk("idle_stray_addr", rom_addr, last_song * 32);
            chk("idle_stray_nn", new_note, 0);
        end
        song = sng[1:0];
        play = 1'b1;
        step();
        play = 1'($urandom_range(0, 1));
        last_song = sng;
        for (int k = 0; k < n; k++) begin
            chk("fetch_addr", rom_addr, sng * 32 + k);
            chk("fetch_nn", new_note, 0);
            if (stray && k == 0) note_done = 1'b1;
            step();
            note_done = 1'b0;
            chk("wait_nn", new_note, 0);
            step();
            chk("emit_nn", new_note, 1);
            chk("emit_note", note, rom[sng * 32 + k][11:6]);
            chk("emit_dur", duration, rom[sng * 32 + k][5:0]);
            last_note = rom[sng * 32 + k][11:6];
            last_dur  = rom[sng * 32 + k][5:0];
            if (stray) note_done = 1'b1;
            if (k == 1 && new_sng >= 0) song = new_sng[1:0];
            step();
            note_done = 1'b0;
            chk("play_nn", new_note, 0);
            if (k == abort_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                chk("rst_addr", rom_addr, 0);
                chk("rst_nn", new_note, 0);
                chk("rst_note", note, 0);
                chk("rst_dur", duration, 0);
                chk("rst_sd", song_done, 0);
                last_song = 0;
                last_note = 0;
                last_dur  = 0;
                play = 1'b0;
                return;
            end
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                step();
                chk("hold_nn", new_note, 0);
                chk("hold_addr", rom_addr, sng * 32 + k);
            end
            play = (k == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
            note_done = 1'b1;
            step();
            note_done = 1'b0;
        end
        play = 1'b0;
        if (n < 32) begin
            chk("end_fetch_addr", rom_addr, sng * 32 + n);
            chk("end_fetch_sd", song_done, 0);
            step();
            chk("end_wait_sd", song_done, 0);
            step();
        end
        chk("done_sd", song_done, 1);
        chk("done_nn", new_note, 0);
        step();
        chk("idle_sd", song_done, 0);
        chk("idle_addr", rom_addr, sng * 32);
        chk("idle_note", note, last_note);
        chk("idle_dur", duration, last_dur);
    endtask

    initial begin
        reset = 1'b1;
        play = 1'b0;
        song = 2'd0;
        note_done = 1'b0;

        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 32; i++)
                rom[s * 32 + i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 63))};
        rom[3] = {6'd9, 6'd0};
        rom[0] = {6'd0, 6'd7};
        rom[64] = {6'd5, 6'd10};
        rom[64 + $urandom_range(1, 31)] = {6'd33, 6'd0};
        if ($urandom_range(0, 1) == 1) rom[96 + $urandom_range(2, 31)] = {6'd1, 6'd0};

        step();
        step();
        reset = 1'b0;
        chk("reset_addr", rom_addr, 0);
        chk("reset_nn", new_note, 0);
        chk("reset_note", note, 0);
        chk("reset_dur", duration, 0);
        chk("reset_sd", song_done, 0);

        run_song(2, -1, 1'b0, -1);
        run_song(0, -1, 1'b1, -1);
        run_song(1, -1, 1'b0, 7);
        run_song(1, -1, 1'b0, -1);
        run_song(1, 3, 1'b0, -1);
        run_song(3, -1, 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
